uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15: maximum cycles in WAIT_HI waiting for uart_tx_busy to rise.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 3: bit i set means requester i presents a byte.
REQ-005 SHALL have port req_data, input, 24: byte of requester i on bits [8i+7:8i].
REQ-006 SHALL have port req_last, input, 3: bit i set means the presented byte is the final byte of requester i's packet.
REQ-007 SHALL have port req_ready, output, 3: one-cycle pulse meaning requester i's byte is accepted.
REQ-008 SHALL have port grant, output, 3: one-hot owner of the UART; 0 when the UART is free.
REQ-009 SHALL have port pkt_done, output, 3: one-cycle pulse when the owner's last byte has finished transmitting.
REQ-010 SHALL have port uart_en, output, 1: one-cycle start pulse to the uart_send block.
REQ-011 SHALL have port uart_din, output, 8: byte to the uart_send block.
REQ-012 SHALL have port uart_tx_busy, input, 1: busy flag from the uart_send block.
REQ-013 SHALL have port err_timeout, output, 1: sticky flag set when busy was not seen after a kick.

Function
REQ-014 SHALL implement states IDLE, LOAD, KICK, WAIT_HI and WAIT_LO.
REQ-015 IDLE: if uart_tx_busy=0 and any req_valid is set, SHALL select a winner by round-robin, set grant one-hot and go to LOAD next cycle; otherwise SHALL stay in IDLE.
REQ-016 Round-robin priority SHALL start at (rr_ptr+1) mod 3 and ascend with wrap; rr_ptr SHALL update to the owner only at packet completion.
REQ-017 LOAD: if req_valid[owner]=1, SHALL drive req_ready[owner]=1 for that cycle, register req_data byte into uart_din, capture req_last[owner] and go to KICK; otherwise SHALL hold in LOAD with grant kept (packet lock).
REQ-018 KICK: SHALL drive uart_en=1 for exactly one cycle, clear the timeout counter and go to WAIT_HI.
REQ-019 WAIT_HI: uart_tx_busy=1 SHALL go to WAIT_LO; after TIMEOUT_CYC cycles with busy low, SHALL set err_timeout and go to WAIT_LO.
REQ-020 WAIT_LO: on uart_tx_busy=0, if the captured last=1, SHALL pulse pkt_done[owner], set rr_ptr=owner, clear grant and go to IDLE; otherwise SHALL go to LOAD.
REQ-021 req_ready SHALL pulse only for the current owner, at most once per byte; req_valid of non-owners SHALL be ignored while grant≠0.
REQ-022 uart_din SHALL hold its value from LOAD until the next accepted byte.
REQ-023 Latency from req_valid in IDLE (busy=0) to uart_en SHALL be 3 cycles: grant at +1, req_ready at +1 (in LOAD), uart_en at +2 relative to the grant edge.
REQ-024 req_last sampled with req_valid=0 SHALL be ignored.
REQ-025 Requests arriving in the same cycle SHALL be resolved solely by round-robin order.

Reset
REQ-026 While rst=1, grant, req_ready, pkt_done, uart_en, uart_din and err_timeout SHALL be 0; state SHALL be IDLE; rr_ptr SHALL be 2, giving requester 0 first priority.
REQ-027 Reset mid-packet SHALL abort the packet with no pkt_done pulse.
REQ-028 After reset, IDLE SHALL withhold any grant until uart_tx_busy=0, so a byte still in flight completes undisturbed.
REQ-029 err_timeout SHALL clear only on rst.

Verification
REQ-030 Single requester 1 sends a 3-byte packet 0x11,0x22,0x33 (last on 0x33) -> three uart_en pulses with uart_din 0x11/0x22/0x33, each issued after busy falls; one pkt_done[1] pulse; grant returns to 0.
REQ-031 After reset, all three requesters are valid simultaneously with 1-byte packets -> grant order is 0,1,2; rr_ptr ends at 2.
REQ-032 Requester 0 stalls req_valid for 10 cycles mid-packet while requester 2 is valid -> grant stays 3'b001; no req_ready to requester 2 until pkt_done[0].
REQ-033 Model holds busy low after a kick -> err_timeout=1 at 15 cycles after uart_en; FSM continues; next byte is still sent.
REQ-034 rst is asserted during WAIT_LO of byte 2 of 4 -> outputs 0 next cycle; no pkt_done; no grant while busy is high; clean re-arbitration afterwards.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send block among three byte-stream requesters, packet-locked.
// Latency: req_valid -> grant +1, req_ready +2, uart_en +3 cycles; owners are held off (no req_ready) until the UART is idle.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ready,
  output logic [2:0]  grant,
  output logic [2:0]  pkt_done,
  output logic        uart_en,
  output logic [7:0]  uart_din,
  input  logic        uart_tx_busy,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT_HI, WAIT_LO} state_t;

  state_t          state;
  logic [1:0]      rr_ptr;
  logic [1:0]      owner;
  logic            last_q;
  logic [CW-1:0]   to_cnt;
  logic            win_vld;
  logic [1:0]      win_idx;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int step);
    int s;
    s = (int'(base) + step) % 3;
    return s[1:0];
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // first valid requester searching upward from the one after the last packet owner
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      if (!win_vld && req_valid[rr_idx(rr_ptr, k)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 2'd2;
      owner       <= 2'd0;
      last_q      <= 1'b0;
      to_cnt      <= '0;
      grant       <= '0;
      req_ready   <= '0;
      pkt_done    <= '0;
      uart_en     <= 1'b0;
      uart_din    <= '0;
      err_timeout <= 1'b0;
    end else begin
      req_ready <= '0;
      pkt_done  <= '0;
      uart_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (!uart_tx_busy && win_vld) begin
            owner <= win_idx;
            grant <= onehot(win_idx);
            state <= LOAD;
          end
        end
        LOAD: begin
          if (req_valid[owner]) begin
            req_ready <= onehot(owner);
            uart_din  <= req_data[{owner, 3'b000} +: 8];
            last_q    <= req_last[owner];
            state     <= KICK;
          end
        end
        KICK: begin
          uart_en <= 1'b1;
          to_cnt  <= '0;
          state   <= WAIT_HI;
        end
        WAIT_HI: begin
          if (uart_tx_busy) begin
            state <= WAIT_LO;
          end else if (to_cnt == CW'(TIMEOUT_CYC - 1)) begin
            err_timeout <= 1'b1;
            state       <= WAIT_LO;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!uart_tx_busy) begin
            if (last_q) begin
              pkt_done <= onehot(owner);
              rr_ptr   <= owner;
              grant    <= '0;
              state    <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
